// File: rtl/pipe_defs_pkg.sv
// Shared widths, register-file types and address helpers for the ID-stage
// register file and its write-back receiver.
package pipe_defs_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned PEND_W = 2;
  localparam int unsigned NREG   = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PEND_W-1:0] pend_t;

  localparam addr_t REG_ZERO = ADDR_W'(0);

  // True when a write-back to waddr lands on the architecturally writable source raddr.
  function automatic logic wb_hit(input logic wena, input addr_t waddr, input addr_t raddr);
    return wena && (waddr == raddr) && (raddr != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_regfile_hilo_if.sv
// WB-write / ID-read bundle of the register file: write-back inputs, ID read
// requests and issue scoreboard updates, plus bypassed read data and stall.
interface pipe_regfile_hilo_if;
  import pipe_defs_pkg::*;

  logic  rf_wena_i;
  addr_t rf_waddr_i;
  data_t rf_wdata_i;
  logic  hi_wena_i;
  data_t hi_wdata_i;
  logic  lo_wena_i;
  data_t lo_wdata_i;

  addr_t rs_addr_i;
  addr_t rt_addr_i;
  logic  rs_used_i;
  logic  rt_used_i;
  logic  pend_set_i;
  addr_t pend_addr_i;

  data_t rs_data_o;
  data_t rt_data_o;
  data_t hi_o;
  data_t lo_o;
  logic  stall_o;

  modport master (
    output rf_wena_i, rf_waddr_i, rf_wdata_i,
    output hi_wena_i, hi_wdata_i, lo_wena_i, lo_wdata_i,
    output rs_addr_i, rt_addr_i, rs_used_i, rt_used_i,
    output pend_set_i, pend_addr_i,
    input  rs_data_o, rt_data_o, hi_o, lo_o, stall_o
  );

  modport slave (
    input  rf_wena_i, rf_waddr_i, rf_wdata_i,
    input  hi_wena_i, hi_wdata_i, lo_wena_i, lo_wdata_i,
    input  rs_addr_i, rt_addr_i, rs_used_i, rt_used_i,
    input  pend_set_i, pend_addr_i,
    output rs_data_o, rt_data_o, hi_o, lo_o, stall_o
  );

endinterface

// File: rtl/pipe_pend_ctr.sv
// Saturating up/down count of in-flight writers to one GPR; simultaneous
// inc and dec cancel, dec at zero holds, inc at max holds.
module pipe_pend_ctr
  import pipe_defs_pkg::*;
#(
  parameter int unsigned W = PEND_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (inc && !dec && (cnt != CNT_MAX)) begin
      cnt_nxt = cnt + W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt_nxt = cnt - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // Pipeline depth bounds the writers in flight; reaching max and issuing again is a bug upstream.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
                                  !(inc && !dec && (cnt == CNT_MAX)))
    else $error("pipe_pend_ctr: pending count overflow");

endmodule

// File: rtl/pipe_regfile_hilo.sv
// ID-stage register file: 32x32 GPRs plus HI/LO written from WB, bypassed
// combinational reads, and a per-GPR pending-writer scoreboard driving stall.
module pipe_regfile_hilo
  import pipe_defs_pkg::*;
(
  input logic                clk,
  input logic                rst,
  pipe_regfile_hilo_if.slave bus
);

  data_t gpr [NREG];
  data_t hi_q;
  data_t lo_q;
  pend_t cnt [NREG];

  logic rf_we;
  logic hit_a;
  logic hit_b;
  logic stall_a;
  logic stall_b;

  assign rf_we = bus.rf_wena_i && (bus.rf_waddr_i != REG_ZERO);

  // GPR storage; r0 is reset and never written, so it always reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        gpr[ADDR_W'(i)] <= '0;
      end
    end else if (rf_we) begin
      gpr[bus.rf_waddr_i] <= bus.rf_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (bus.hi_wena_i) hi_q <= bus.hi_wdata_i;
      if (bus.lo_wena_i) lo_q <= bus.lo_wdata_i;
    end
  end

  // Scoreboard: one counter per writable GPR, r0 pinned at zero.
  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_pend
    logic inc_r;
    logic dec_r;

    assign inc_r = bus.pend_set_i && (bus.pend_addr_i == ADDR_W'(r));
    assign dec_r = bus.rf_wena_i  && (bus.rf_waddr_i  == ADDR_W'(r));

    pipe_pend_ctr #(.W(PEND_W)) u_ctr (
      .clk (clk),
      .rst (rst),
      .inc (inc_r),
      .dec (dec_r),
      .cnt (cnt[r])
    );
  end

  assign hit_a = wb_hit(bus.rf_wena_i, bus.rf_waddr_i, bus.rs_addr_i);
  assign hit_b = wb_hit(bus.rf_wena_i, bus.rf_waddr_i, bus.rt_addr_i);

  // Read ports with same-cycle write-through from WB.
  always_comb begin
    bus.rs_data_o = gpr[bus.rs_addr_i];
    bus.rt_data_o = gpr[bus.rt_addr_i];
    if (bus.rs_addr_i == REG_ZERO) begin
      bus.rs_data_o = '0;
    end else if (hit_a) begin
      bus.rs_data_o = bus.rf_wdata_i;
    end
    if (bus.rt_addr_i == REG_ZERO) begin
      bus.rt_data_o = '0;
    end else if (hit_b) begin
      bus.rt_data_o = bus.rf_wdata_i;
    end
  end

  always_comb begin
    bus.hi_o = bus.hi_wena_i ? bus.hi_wdata_i : hi_q;
    bus.lo_o = bus.lo_wena_i ? bus.lo_wdata_i : lo_q;
  end

  // A writer currently in WB is covered by the bypass; any further pending writer is younger data.
  always_comb begin
    stall_a = bus.rs_used_i && (bus.rs_addr_i != REG_ZERO) &&
              (cnt[bus.rs_addr_i] > PEND_W'(hit_a));
    stall_b = bus.rt_used_i && (bus.rt_addr_i != REG_ZERO) &&
              (cnt[bus.rt_addr_i] > PEND_W'(hit_b));
    bus.stall_o = stall_a || stall_b;
  end

  a_no_issue_on_stall: assert property (@(posedge clk) disable iff (rst)
                                        !(bus.pend_set_i && bus.stall_o))
    else $error("pipe_regfile_hilo: pend_set_i while stall_o");

endmodule

// File: tb/tb_pipe_regfile_hilo.sv
// Bench for pipe_regfile_hilo: directed vector table, a mid-flight reset
// sequence, and random traffic against an array/counter reference model.
module tb_pipe_regfile_hilo;
  import pipe_defs_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipe_regfile_hilo_if bus ();

  pipe_regfile_hilo dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        wena;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hwe;
    logic [31:0] hwd;
    logic        lwe;
    logic [31:0] lwd;
    logic [4:0]  rs;
    logic        rsu;
    logic [4:0]  rt;
    logic        rtu;
    logic        pset;
    logic [4:0]  paddr;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_hi;
    logic [31:0] e_lo;
    logic        e_stall;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: architectural registers and writers-in-flight per GPR.
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          m_pend [32];

  vec_t tbl [$];

  function automatic vec_t mk(
    input logic wena, input logic [4:0] waddr, input logic [31:0] wdata,
    input logic hwe, input logic [31:0] hwd, input logic lwe, input logic [31:0] lwd,
    input logic [4:0] rs, input logic rsu, input logic [4:0] rt, input logic rtu,
    input logic pset, input logic [4:0] paddr,
    input logic [31:0] e_rs, input logic [31:0] e_rt,
    input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_stall);
    vec_t v;
    v.wena = wena; v.waddr = waddr; v.wdata = wdata;
    v.hwe = hwe; v.hwd = hwd; v.lwe = lwe; v.lwd = lwd;
    v.rs = rs; v.rsu = rsu; v.rt = rt; v.rtu = rtu;
    v.pset = pset; v.paddr = paddr;
    v.e_rs = e_rs; v.e_rt = e_rt; v.e_hi = e_hi; v.e_lo = e_lo; v.e_stall = e_stall;
    return v;
  endfunction

  function automatic vec_t idle_rd(input logic [4:0] rs, input logic rsu,
                                   input logic [4:0] rt, input logic rtu);
    return mk(0, 0, 0, 0, 0, 0, 0, rs, rsu, rt, rtu, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a, input vec_t v);
    if (a == 5'd0) return 32'd0;
    if (v.wena && v.waddr == a) return v.wdata;
    return m_gpr[a];
  endfunction

  function automatic logic m_src_stall(input logic used, input logic [4:0] a, input vec_t v);
    int covered;
    covered = (v.wena && v.waddr == a) ? 1 : 0;
    return used && (a != 5'd0) && (m_pend[a] > covered);
  endfunction

  function automatic vec_t model_expect(input vec_t v);
    vec_t r;
    r = v;
    r.e_rs = m_read(v.rs, v);
    r.e_rt = m_read(v.rt, v);
    r.e_hi = v.hwe ? v.hwd : m_hi;
    r.e_lo = v.lwe ? v.lwd : m_lo;
    r.e_stall = m_src_stall(v.rsu, v.rs, v) || m_src_stall(v.rtu, v.rt, v);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_gpr[i] = 32'd0;
      m_pend[i] = 0;
    end
    m_hi = 32'd0;
    m_lo = 32'd0;
  endtask

  task automatic model_step(input vec_t v);
    int n;
    if (v.wena && v.waddr != 5'd0) m_gpr[v.waddr] = v.wdata;
    if (v.hwe) m_hi = v.hwd;
    if (v.lwe) m_lo = v.lwd;
    for (int r = 1; r < 32; r++) begin
      n = m_pend[r];
      if (v.pset && v.paddr == 5'(r)) n = n + 1;
      if (v.wena && v.waddr == 5'(r)) n = n - 1;
      if (n < 0) n = 0;
      if (n > 3) n = 3;
      m_pend[r] = n;
    end
  endtask

  task automatic drive(input vec_t v);
    bus.rf_wena_i   = v.wena;
    bus.rf_waddr_i  = v.waddr;
    bus.rf_wdata_i  = v.wdata;
    bus.hi_wena_i   = v.hwe;
    bus.hi_wdata_i  = v.hwd;
    bus.lo_wena_i   = v.lwe;
    bus.lo_wdata_i  = v.lwd;
    bus.rs_addr_i   = v.rs;
    bus.rs_used_i   = v.rsu;
    bus.rt_addr_i   = v.rt;
    bus.rt_used_i   = v.rtu;
    bus.pend_set_i  = v.pset;
    bus.pend_addr_i = v.paddr;
  endtask

  task automatic cmp(input string tag, input string nm,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s %s: actual=%h required=%h", tag, nm, act, exp);
    end
  endtask

  task automatic check(input vec_t v, input string tag);
    cmp(tag, "rs_data", bus.rs_data_o, v.e_rs);
    cmp(tag, "rt_data", bus.rt_data_o, v.e_rt);
    cmp(tag, "hi", bus.hi_o, v.e_hi);
    cmp(tag, "lo", bus.lo_o, v.e_lo);
    cmp(tag, "stall", 32'(bus.stall_o), 32'(v.e_stall));
  endtask

  // One ID cycle: drive, let comb settle, check, commit on the edge.
  task automatic cycle(input vec_t v, input string tag);
    drive(v);
    #2;
    check(v, tag);
    @(posedge clk);
    #1;
    model_step(v);
  endtask

  initial begin
    vec_t v;

    // Directed sequence from reset (hand-derived expectations).
    tbl.push_back(idle_rd(5, 1, 0, 1));
    tbl.push_back(mk(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(idle_rd(0, 1, 0, 1));
    tbl.push_back(mk(1, 3, 32'h1234_5678, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 32'h1234_5678, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 1, 3, 1, 0, 0, 32'h1234_5678, 32'h1234_5678, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 7, 32'hAA, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 32'hAA, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 32'hAA, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 9, 32'h11, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 32'h11, 0, 0, 1));
    tbl.push_back(mk(1, 9, 32'h22, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 32'h22, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 32'h22, 0, 0, 0));
    tbl.push_back(mk(1, 4, 32'h44, 1, 32'h1, 1, 32'h2, 4, 1, 9, 1, 1, 4, 32'h44, 32'h22, 32'h1, 32'h2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 1, 3, 1, 0, 0, 32'h44, 32'h1234_5678, 32'h1, 32'h2, 0));
    tbl.push_back(mk(1, 4, 32'h55, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 32'h55, 0, 32'h1, 32'h2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1, 4, 32'h55, 0, 32'h1, 32'h2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 32'h55, 0, 32'h1, 32'h2, 1));
    tbl.push_back(mk(1, 4, 32'h66, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 32'h66, 0, 32'h1, 32'h2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'hCAFE, 0, 0, 4, 1, 0, 0, 0, 0, 32'h66, 0, 32'hCAFE, 32'h2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 32'hCAFE, 32'h2, 0));
    tbl.push_back(mk(0, 0, 0, 1, 32'h4, 1, 32'h3, 7, 1, 3, 1, 0, 0, 32'hAA, 32'h1234_5678, 32'h4, 32'h3, 0));
    tbl.push_back(idle_rd(0, 1, 7, 1));

    // Reset state, checked while rst is held.
    rst = 1'b1;
    model_reset();
    drive(idle_rd(5, 1, 0, 1));
    #2;
    check(idle_rd(5, 1, 0, 1), "reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      // The last row needs hi/lo from the previous one; patch its expectations from constants.
      if (i == tbl.size() - 1) begin
        tbl[i].e_rt = 32'hAA;
        tbl[i].e_hi = 32'h4;
        tbl[i].e_lo = 32'h3;
      end
      cycle(tbl[i], $sformatf("vec%0d", i));
    end

    // Mid-flight reset with two writers pending on r6.
    cycle(model_expect(mk(0, 0, 0, 0, 0, 0, 0, 6, 0, 3, 0, 1, 6, 0, 0, 0, 0, 0)), "rstseq_set1");
    cycle(model_expect(mk(0, 0, 0, 0, 0, 0, 0, 6, 0, 3, 0, 1, 6, 0, 0, 0, 0, 0)), "rstseq_set2");
    v = idle_rd(6, 1, 3, 1);
    drive(v);
    #2;
    cmp("rstseq_pre", "stall", 32'(bus.stall_o), 32'd1);
    cmp("rstseq_pre", "rt_data", bus.rt_data_o, 32'h1234_5678);
    rst = 1'b1;
    #1;
    check(idle_rd(6, 1, 3, 1), "rstseq_async");
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cycle(idle_rd(6, 1, 3, 1), "rstseq_after");

    // Random traffic on a small address window so hazards and bypasses collide often.
    for (int n = 0; n < 600; n++) begin
      v.wena  = ($urandom_range(0, 2) != 0);
      v.waddr = 5'($urandom_range(0, 7));
      v.wdata = $urandom;
      v.hwe   = ($urandom_range(0, 3) == 0);
      v.hwd   = $urandom;
      v.lwe   = ($urandom_range(0, 3) == 0);
      v.lwd   = $urandom;
      v.rs    = 5'($urandom_range(0, 7));
      v.rsu   = 1'($urandom_range(0, 1));
      v.rt    = 5'($urandom_range(0, 7));
      v.rtu   = 1'($urandom_range(0, 1));
      v.paddr = 5'($urandom_range(0, 7));
      v.pset  = 1'b0;
      v = model_expect(v);
      if (!v.e_stall && ($urandom_range(0, 1) == 1) &&
          (v.paddr == 5'd0 || m_pend[v.paddr] < 3)) begin
        v.pset = 1'b1;
      end
      cycle(v, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
